// File: rtl/mkio_pkg.sv
// Shared MIL-STD-1553B word definitions used by the transmitter and the receiver/decoder.
package mkio_pkg;

    localparam logic [5:0] SYNC_CMD   = 6'b111000;
    localparam logic [5:0] SYNC_DATA  = 6'b000111;
    localparam int         WORD_CELLS = 40;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } mkio_tx_state_t;

    // 40 half-bit cells, MSB first: sync, {d,~d} per data bit (bit 15 first), then {p,~p} with odd parity.
    function automatic logic [39:0] mkio_frame(input logic sync, input logic [15:0] data);
        logic [39:0] f;
        logic        p;
        f[39:34] = sync ? SYNC_CMD : SYNC_DATA;
        for (int i = 0; i < 16; i++) begin
            f[2*i+3] = data[i];
            f[2*i+2] = ~data[i];
        end
        p    = ~(^data);
        f[1] = p;
        f[0] = ~p;
        return f;
    endfunction

endpackage

// File: rtl/mkio_halfbit_timer.sv
// Half-bit cell prescaler: counts 0..CLK_PER_HALFBIT-1 while running, ticks on the last count.
module mkio_halfbit_timer #(
    parameter int CLK_PER_HALFBIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run_i,
    output logic cell_tick_o
);

    localparam int CW = (CLK_PER_HALFBIT > 1) ? $clog2(CLK_PER_HALFBIT) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          wrap;

    assign wrap        = (cnt_q == CW'(CLK_PER_HALFBIT - 1));
    assign cell_tick_o = run_i & wrap;

    // Held at zero whenever not running so every word starts on a full cell.
    always_comb begin
        cnt_d = cnt_q;
        if (!run_i || wrap) cnt_d = '0;
        else                cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/mkio_word_tx.sv
// MIL-STD-1553B Manchester-II word transmitter for one bus channel, with a one-entry holding register.
module mkio_word_tx
    import mkio_pkg::*;
#(
    parameter int CLK_PER_HALFBIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tx_valid,
    input  logic        tx_sync,
    input  logic [15:0] tx_data,
    output logic        tx_ready,
    input  logic        tx_abort,
    output logic        tx_busy,
    output logic        tx_done,
    output logic        DO1,
    output logic        DO0,
    output logic        TX_INHIBIT
);

    mkio_tx_state_t state_q, state_d;
    logic [39:0]    sr_q, sr_d;
    logic [5:0]     cell_q, cell_d;
    logic           hold_full_q, hold_full_d;
    logic           hold_sync_q, hold_sync_d;
    logic [15:0]    hold_data_q, hold_data_d;
    logic           done_q, done_d;

    logic accept, cell_tick, last_tick, busy;

    assign busy      = (state_q == SEND);
    assign accept    = tx_valid & ~hold_full_q & ~tx_abort;
    assign last_tick = cell_tick & (cell_q == 6'(WORD_CELLS - 1));

    mkio_halfbit_timer #(.CLK_PER_HALFBIT(CLK_PER_HALFBIT)) u_timer (
        .clk         (clk),
        .rst_n       (reset),
        .run_i       (busy & ~tx_abort),
        .cell_tick_o (cell_tick)
    );

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        cell_d      = cell_q;
        hold_full_d = hold_full_q;
        hold_sync_d = hold_sync_q;
        hold_data_d = hold_data_q;
        done_d      = 1'b0;
        if (tx_abort) begin
            state_d     = IDLE;
            sr_d        = '0;
            cell_d      = '0;
            hold_full_d = 1'b0;
            hold_sync_d = 1'b0;
            hold_data_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        sr_d    = mkio_frame(tx_sync, tx_data);
                        cell_d  = '0;
                        state_d = SEND;
                    end
                end
                SEND: begin
                    if (last_tick) begin
                        done_d = 1'b1;
                        cell_d = '0;
                        if (hold_full_q) begin
                            sr_d        = mkio_frame(hold_sync_q, hold_data_q);
                            hold_full_d = 1'b0;
                        end else if (accept) begin
                            // A word arriving on the final tick goes straight out, keeping the stream gap-free.
                            sr_d = mkio_frame(tx_sync, tx_data);
                        end else begin
                            sr_d    = '0;
                            state_d = IDLE;
                        end
                    end else if (cell_tick) begin
                        sr_d   = {sr_q[38:0], 1'b0};
                        cell_d = cell_q + 6'd1;
                    end
                    if (accept && !last_tick) begin
                        hold_full_d = 1'b1;
                        hold_sync_d = tx_sync;
                        hold_data_d = tx_data;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            cell_q      <= '0;
            hold_full_q <= 1'b0;
            hold_sync_q <= 1'b0;
            hold_data_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            cell_q      <= cell_d;
            hold_full_q <= hold_full_d;
            hold_sync_q <= hold_sync_d;
            hold_data_q <= hold_data_d;
            done_q      <= done_d;
        end
    end

    // Lines are gated by busy so an async reset drops them without waiting for a clock.
    assign tx_ready   = ~hold_full_q;
    assign tx_busy    = busy;
    assign tx_done    = done_q;
    assign DO1        = busy & sr_q[39];
    assign DO0        = busy & ~sr_q[39];
    assign TX_INHIBIT = ~busy;

endmodule

// File: tb/tb_mkio_word_tx.sv
// Randomized and directed bench for mkio_word_tx against a queue-based word-stream model.
`timescale 1ns/1ps
module tb_mkio_word_tx;

    localparam int CPH  = 16;
    localparam int WLEN = 40 * CPH;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        tx_valid = 1'b0, tx_sync = 1'b0, tx_abort = 1'b0;
    logic [15:0] tx_data = '0;
    logic        tx_ready, tx_busy, tx_done, DO1, DO0, TX_INHIBIT;

    int vectors = 0;
    int miscompares = 0;

    mkio_word_tx #(.CLK_PER_HALFBIT(CPH)) dut (
        .clk(clk), .reset(reset), .tx_valid(tx_valid), .tx_sync(tx_sync), .tx_data(tx_data),
        .tx_ready(tx_ready), .tx_abort(tx_abort), .tx_busy(tx_busy), .tx_done(tx_done),
        .DO1(DO1), .DO0(DO0), .TX_INHIBIT(TX_INHIBIT)
    );

    always #15.625 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Frame built as a bit string appended in transmit order.
    function automatic logic [39:0] model_frame(input logic sync, input logic [15:0] data);
        logic [39:0] f;
        int ones;
        logic p;
        f = sync ? 40'b111000 : 40'b000111;
        ones = 0;
        for (int i = 15; i >= 0; i--) begin
            f = {f[37:0], data[i], ~data[i]};
            ones += data[i];
        end
        p = ((ones + 1) % 2 == 0) ? 1'b1 : 1'b0;
        p = ~p ? 1'b0 : 1'b1;
        p = (ones % 2 == 0);
        f = {f[37:0], p, ~p};
        return f;
    endfunction

    // Model: current word, position within it in clocks, and pending-word queue (depth 1).
    logic [39:0] cur, nw;
    logic [39:0] pend[$];
    int          pos;
    bit          mbusy, mdone, acc;

    initial forever begin
        @(posedge clk or negedge reset);
        if (!reset) begin
            pend.delete(); mbusy = 0; mdone = 0; pos = 0; cur = '0;
        end else if (tx_abort) begin
            pend.delete(); mbusy = 0; mdone = 0; pos = 0;
        end else begin
            acc   = tx_valid && (pend.size() == 0);
            nw    = model_frame(tx_sync, tx_data);
            mdone = 0;
            if (mbusy) begin
                pos++;
                if (pos == WLEN) begin
                    mdone = 1; pos = 0;
                    if (pend.size() > 0) cur = pend.pop_front();
                    else if (acc) begin cur = nw; acc = 0; end
                    else mbusy = 0;
                end
            end
            if (acc) begin
                if (!mbusy) begin cur = nw; mbusy = 1; pos = 0; end
                else pend.push_back(nw);
            end
        end
    end

    function automatic logic [5:0] model_out();
        logic l;
        l = mbusy ? cur[39 - pos / CPH] : 1'b0;
        return {mbusy, l, mbusy & ~l, ~mbusy, pend.size() == 0, mdone};
    endfunction

    initial forever begin
        @(negedge clk);
        if (reset) chk("cycle{busy,DO1,DO0,INH,ready,done}",
                       {58'd0, tx_busy, DO1, DO0, TX_INHIBIT, tx_ready, tx_done}, {58'd0, model_out()});
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic send(input logic s, input logic [15:0] d);
        logic r;
        int n;
        tx_valid = 1; tx_sync = s; tx_data = d;
        n = 0;
        do begin
            r = tx_ready;
            cyc();
            n++;
        end while (!r && n < 2000);
        if (!r) chk("send_timeout", 64'd0, 64'd1);
        tx_valid = 0;
    endtask

    // Called right after an accept edge: decodes DO1 mid-cell and counts busy/done cycles.
    task automatic decode_word(output logic [39:0] w, output int nb, output int nd);
        w = '0; nb = 0; nd = 0;
        for (int c = 0; c < 700; c++) begin
            if (c < WLEN && c % CPH == CPH / 2) w = {w[38:0], DO1};
            nb += tx_busy; nd += tx_done;
            cyc();
        end
    endtask

    logic [39:0] w;
    logic [79:0] w2;
    int nb, nd, wt;

    initial begin
        // Model pinned by hand-computed frames.
        chk("frame_0847", model_frame(1'b1, 16'h0847), {6'b111000, 32'h5595656A, 2'b01});
        chk("frame_FFFF", model_frame(1'b0, 16'hFFFF), {6'b000111, 32'hAAAAAAAA, 2'b10});
        chk("frame_0000", model_frame(1'b0, 16'h0000), {6'b000111, 32'h55555555, 2'b10});

        #40; reset = 1'b1;
        cyc();
        repeat (100) cyc();
        chk("idle_lines", {DO1, DO0, TX_INHIBIT, tx_ready, tx_busy, tx_done}, 6'b001100);

        // Status word
        send(1'b1, 16'h0847);
        decode_word(w, nb, nd);
        chk("t2_frame", w, {6'b111000, 32'h5595656A, 2'b01});
        chk("t2_busy_cycles", nb, WLEN);
        chk("t2_done_count", nd, 1);

        // Back-to-back data words, second offered during the first
        send(1'b0, 16'hFFFF);
        w2 = '0; nb = 0; nd = 0;
        for (int c = 0; c < 1400; c++) begin
            if (c == 100) begin tx_valid = 1; tx_sync = 0; tx_data = 16'h0000; end
            if (c == 101) tx_valid = 0;
            if (c < 2 * WLEN && c % CPH == CPH / 2) w2 = {w2[78:0], DO1};
            nb += tx_busy; nd += tx_done;
            cyc();
        end
        chk("t3_frame1", w2[79:40], {6'b000111, 32'hAAAAAAAA, 2'b10});
        chk("t3_frame2", w2[39:0], {6'b000111, 32'h55555555, 2'b10});
        chk("t3_busy_cycles", nb, 2 * WLEN);
        chk("t3_done_count", nd, 2);

        // Third word stalls until the first reload
        send(1'b1, 16'h1234);
        send(1'b0, 16'h5678);
        tx_valid = 1; tx_sync = 0; tx_data = 16'h9ABC;
        chk("t4_ready_full", tx_ready, 1'b0);
        wt = 0;
        while (!tx_ready && wt < 2000) begin cyc(); wt++; end
        cyc();
        tx_valid = 0;
        chk("t4_wait_gt600", wt > 600, 1'b1);
        repeat (2 * WLEN + 10) cyc();
        chk("t4_idle", {tx_busy, TX_INHIBIT}, 2'b01);

        // Abort at cycle 300 with a held word; concurrent tx_valid ignored
        send(1'b1, 16'hBEEF);
        send(1'b0, 16'hCAFE);
        repeat (299) cyc();
        tx_abort = 1; tx_valid = 1; tx_data = 16'h1111;
        cyc();
        tx_abort = 0; tx_valid = 0;
        chk("t5_lines", {DO1, DO0, TX_INHIBIT, tx_busy, tx_ready}, 5'b00101);
        nb = 0; nd = 0;
        for (int c = 0; c < 700; c++) begin nb += tx_busy; nd += tx_done; cyc(); end
        chk("t5_no_busy", nb, 0);
        chk("t5_no_done", nd, 0);

        // Async reset during the parity cells
        send(1'b0, 16'h00F0);
        repeat (620) cyc();
        #5 reset = 1'b0;
        #1 chk("t6_reset_outs", {DO1, DO0, TX_INHIBIT, tx_ready, tx_busy, tx_done}, 6'b001100);
        repeat (3) @(posedge clk);
        #5 reset = 1'b1;
        cyc();
        send(1'b1, 16'hA5C3);
        decode_word(w, nb, nd);
        chk("t6_frame", w, model_frame(1'b1, 16'hA5C3));
        chk("t6_busy_cycles", nb, WLEN);

        // Random traffic with occasional aborts
        for (int c = 0; c < 30000; c++) begin
            tx_valid = ($urandom_range(0, 7) == 0);
            tx_sync  = $urandom_range(0, 1);
            tx_data  = 16'($urandom);
            tx_abort = ($urandom_range(0, 3999) == 0);
            cyc();
        end
        tx_valid = 0; tx_abort = 0;
        repeat (2 * WLEN + 20) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
